bram_port_adapter: RTL and testbench

- Valid/ready front end for one port of the true dual-port byte-enable block RAM; sits directly upstream of the RAM port and also consumes its read data.
- Converts a request stream (read or byte-masked write) into RAM port strobes.
- Tracks the one-cycle read latency and captures read data into a response FIFO, so consumers may stall without losing data.

---
 rtl/bram_port_adapter.sv | 107 ++++++++++
 tb/tb_bram_port_adapter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_adapter.sv
// bram_port_adapter: valid/ready request front end for one port of a byte-enable block RAM,
// with read-latency tracking and a response FIFO. Option: BRAM_PORT_ADAPTER_WRITE_ACK_EN.
module bram_port_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BE_WIDTH-1:0]   req_be,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [BE_WIDTH-1:0]   ram_be,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam int PTR_WIDTH = $clog2(RESP_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam int OCC_WIDTH = CNT_WIDTH + 1;
  localparam logic [OCC_WIDTH-1:0] OCC_LIMIT = OCC_WIDTH'(RESP_DEPTH);

  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  inflight;
  logic [OCC_WIDTH-1:0]  occ;
  logic                  fire;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;

  // A slot is reserved at issue time, so the FIFO can always absorb the RAM's output.
  assign occ       = OCC_WIDTH'(count) + OCC_WIDTH'(inflight);
  assign req_ready = !RST && (occ < OCC_LIMIT);
  assign fire      = req_valid && req_ready;

  assign ram_we   = fire && req_we;
  assign ram_re   = fire && !req_we;
  assign ram_addr = req_addr;
  assign ram_be   = req_be;
  assign ram_di   = req_data;

`ifdef BRAM_PORT_ADAPTER_WRITE_ACK_EN
  logic inflight_wr;

  assign issue     = fire;
  assign push_data = inflight_wr ? '0 : ram_do;

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_wr <= 1'b0;
    end else begin
      inflight_wr <= ram_we;
    end
  end
`else
  assign issue     = ram_re;
  assign push_data = ram_do;
`endif

  assign push       = inflight && !RST;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = fifo_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_bram_port_adapter.sv
// Bench for bram_port_adapter: behavioural RAM on the port side, a memory/queue
// reference model for responses, and randomized plus directed scenarios.
module tb_bram_port_adapter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int DEPTH = 4;
`ifdef BRAM_PORT_ADAPTER_WRITE_ACK_EN
  localparam int WACK = 1;
`else
  localparam int WACK = 0;
`endif

  logic          clk;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_be;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_re;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bram_port_adapter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RESP_DEPTH(DEPTH)
  ) dut (
    .CLK(clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
    .ram_be(ram_be), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Behavioural RAM port: byte-enable write and registered read, one cycle latency.
  logic          ram_init;
  logic [DW-1:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= init_val(i);
    end else begin
      if (ram_we)
        for (int b = 0; b < BW; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
      if (ram_re) ram_do <= ram_mem[ram_addr];
    end
  end

  // Reference model: memory image plus queue of outstanding responses tagged with issue cycle.
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] sb_data [$];
  int            sb_cyc  [$];

  typedef struct packed {
    logic          ready;
    logic          rv;
    logic          re;
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  task automatic drive_step(input logic rst_i, input logic v, input logic we,
                            input logic [AW-1:0] a, input logic [BW-1:0] be,
                            input logic [DW-1:0] d, input logic rr, output exp_t e);
    @(negedge clk);
    RST = rst_i; req_valid = v; req_we = we; req_addr = a;
    req_be = be; req_data = d; resp_ready = rr;
    #1;
    e.ready = !rst_i && (sb_data.size() < DEPTH);
    e.re    = v && e.ready && !we;
    e.we    = v && e.ready && we;
    e.rv    = (sb_data.size() > 0) && (sb_cyc[0] + 2 <= cyc);
    e.data  = e.rv ? sb_data[0] : '0;
    if (e.rv && rr) begin
      void'(sb_data.pop_front());
      void'(sb_cyc.pop_front());
    end
    if (e.we) begin
      for (int b = 0; b < BW; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      if (WACK != 0) begin
        sb_data.push_back('0);
        sb_cyc.push_back(cyc);
      end
    end
    if (e.re) begin
      sb_data.push_back(ref_mem[a]);
      sb_cyc.push_back(cyc);
    end
    if (rst_i) begin
      sb_data.delete();
      sb_cyc.delete();
    end
    cyc++;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd3;
    #1;
    checks += 2;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    if (ram_re !== 1'b0) begin failures++; $display("FAIL reset_ram_re got=%b exp=0", ram_re); end
    req_we = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    for (int k = 0; k < 3; k++) begin
      drive_step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, e);
      checks += 5;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL idle_resp_valid got=%b exp=0", resp_valid); end
      if ({ram_re, ram_we} !== 2'b00) begin failures++; $display("FAIL idle_strobes got=%b exp=00", {ram_re, ram_we}); end
      if (req_ready !== e.ready) begin failures++; $display("FAIL idle_model_ready got=%b exp=%b", req_ready, e.ready); end
      if (resp_valid !== e.rv) begin failures++; $display("FAIL idle_model_rv got=%b exp=%b", resp_valid, e.rv); end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [DW-1:0] got [$];
    int t_done = -1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      drive_step(1'b0, 1'b1, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b1, e);
      else if (k == 1) drive_step(1'b0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0, 1'b1, e);
      else             drive_step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, e);
      checks += 3;
      if (req_ready !== e.ready) begin failures++; $display("FAIL wr_rd_ready got=%b exp=%b cyc=%0d", req_ready, e.ready, cyc); end
      if (resp_valid !== e.rv) begin failures++; $display("FAIL wr_rd_rv got=%b exp=%b cyc=%0d", resp_valid, e.rv, cyc); end
      if ({ram_re, ram_we} !== {e.re, e.we}) begin failures++; $display("FAIL wr_rd_strobes got=%b exp=%b cyc=%0d", {ram_re, ram_we}, {e.re, e.we}, cyc); end
      if (e.rv) begin
        checks++;
        if (resp_data !== e.data) begin failures++; $display("FAIL wr_rd_data got=%h exp=%h cyc=%0d", resp_data, e.data, cyc); end
      end
      if (resp_valid && resp_ready) begin
        got.push_back(resp_data);
        if (got.size() == 1 + WACK && t_done < 0) t_done = k;
      end
    end
    checks++;
    if (got.size() != 1 + WACK) begin
      failures++; $display("FAIL wr_rd_count got=%0d exp=%0d", got.size(), 1 + WACK);
    end else begin
      checks += 2;
      if (got[WACK] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_value got=%h exp=deadbeef", got[WACK]); end
      if (t_done - 1 != 2) begin failures++; $display("FAIL wr_rd_latency got=%0d exp=2", t_done - 1); end
    end
  endtask

  task automatic test_byte_enable();
    exp_t e;
    logic [DW-1:0] got [$];
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      drive_step(1'b0, 1'b1, 1'b1, 10'd2, 4'hF, 32'hFFFFFFFF, 1'b1, e);
      else if (k == 1) drive_step(1'b0, 1'b1, 1'b1, 10'd2, 4'b0010, 32'h00001200, 1'b1, e);
      else if (k == 2) drive_step(1'b0, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b1, e);
      else             drive_step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, e);
      checks += 3;
      if (req_ready !== e.ready) begin failures++; $display("FAIL be_ready got=%b exp=%b cyc=%0d", req_ready, e.ready, cyc); end
      if (resp_valid !== e.rv) begin failures++; $display("FAIL be_rv got=%b exp=%b cyc=%0d", resp_valid, e.rv, cyc); end
      if ({ram_re, ram_we} !== {e.re, e.we}) begin failures++; $display("FAIL be_strobes got=%b exp=%b cyc=%0d", {ram_re, ram_we}, {e.re, e.we}, cyc); end
      if (e.rv) begin
        checks++;
        if (resp_data !== e.data) begin failures++; $display("FAIL be_data got=%h exp=%h cyc=%0d", resp_data, e.data, cyc); end
      end
      if (resp_valid && resp_ready) got.push_back(resp_data);
    end
    checks++;
    if (got.size() != 1 + 2 * WACK) begin
      failures++; $display("FAIL be_count got=%0d exp=%0d", got.size(), 1 + 2 * WACK);
    end else begin
      checks++;
      if (got[2 * WACK] !== 32'hFFFF12FF) begin failures++; $display("FAIL be_value got=%h exp=ffff12ff", got[2 * WACK]); end
    end
  endtask

  task automatic test_full_backpressure();
    exp_t e;
    logic [DW-1:0] got [$];
    int nacc = 0;
    int dut_acc = 0;
    for (int k = 0; k < 40; k++) begin
      drive_step(1'b0, nacc < 6, 1'b0, 10'(nacc), '0, '0, k >= 10, e);
      checks += 3;
      if (req_ready !== e.ready) begin failures++; $display("FAIL full_ready got=%b exp=%b cyc=%0d", req_ready, e.ready, cyc); end
      if (resp_valid !== e.rv) begin failures++; $display("FAIL full_rv got=%b exp=%b cyc=%0d", resp_valid, e.rv, cyc); end
      if ({ram_re, ram_we} !== {e.re, e.we}) begin failures++; $display("FAIL full_strobes got=%b exp=%b cyc=%0d", {ram_re, ram_we}, {e.re, e.we}, cyc); end
      if (e.rv) begin
        checks++;
        if (resp_data !== e.data) begin failures++; $display("FAIL full_data got=%h exp=%h cyc=%0d", resp_data, e.data, cyc); end
      end
      if (ram_re) dut_acc++;
      if (e.re) nacc++;
      if (resp_valid && resp_ready) got.push_back(resp_data);
      if (k == 9) begin
        checks++;
        if (dut_acc != 4) begin failures++; $display("FAIL full_accept_count got=%0d exp=4", dut_acc); end
      end
    end
    checks++;
    if (got.size() != 6) begin
      failures++; $display("FAIL full_resp_count got=%0d exp=6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== ref_mem[i]) begin failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, got[i], ref_mem[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int dut_acc = 0;
    int nresp = 0;
    int first_rv = -1;
    int last_rv = -1;
    for (int k = 0; k < 22; k++) begin
      drive_step(1'b0, k < 16, 1'b0, 10'($urandom_range(1023)), '0, '0, 1'b1, e);
      checks += 3;
      if (req_ready !== e.ready) begin failures++; $display("FAIL b2b_ready got=%b exp=%b cyc=%0d", req_ready, e.ready, cyc); end
      if (resp_valid !== e.rv) begin failures++; $display("FAIL b2b_rv got=%b exp=%b cyc=%0d", resp_valid, e.rv, cyc); end
      if ({ram_re, ram_we} !== {e.re, e.we}) begin failures++; $display("FAIL b2b_strobes got=%b exp=%b cyc=%0d", {ram_re, ram_we}, {e.re, e.we}, cyc); end
      if (e.rv) begin
        checks++;
        if (resp_data !== e.data) begin failures++; $display("FAIL b2b_data got=%h exp=%h cyc=%0d", resp_data, e.data, cyc); end
      end
      if (ram_re) dut_acc++;
      if (resp_valid) begin
        nresp++;
        if (first_rv < 0) first_rv = k;
        last_rv = k;
      end
    end
    checks += 3;
    if (dut_acc != 16) begin failures++; $display("FAIL b2b_accepts got=%0d exp=16", dut_acc); end
    if (nresp != 16) begin failures++; $display("FAIL b2b_responses got=%0d exp=16", nresp); end
    if (last_rv - first_rv + 1 != 16) begin failures++; $display("FAIL b2b_bubbles span=%0d exp=16", last_rv - first_rv + 1); end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int stale = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 2)       drive_step(1'b0, 1'b1, 1'b0, 10'(7 + k), '0, '0, 1'b0, e);
      else if (k == 2) drive_step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, e);
      else             drive_step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, e);
      checks += 3;
      if (req_ready !== e.ready) begin failures++; $display("FAIL rstmid_ready got=%b exp=%b cyc=%0d", req_ready, e.ready, cyc); end
      if (resp_valid !== e.rv) begin failures++; $display("FAIL rstmid_rv got=%b exp=%b cyc=%0d", resp_valid, e.rv, cyc); end
      if ({ram_re, ram_we} !== {e.re, e.we}) begin failures++; $display("FAIL rstmid_strobes got=%b exp=%b cyc=%0d", {ram_re, ram_we}, {e.re, e.we}, cyc); end
      if (k >= 3 && resp_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_random();
    exp_t e;
    logic v, we, rr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
    for (int k = 0; k < 420; k++) begin
      v  = (k < 400) && ($urandom_range(99) < 75);
      we = $urandom_range(99) < 40;
      rr = (k >= 400) || ($urandom_range(99) < 70);
      a  = 10'($urandom_range(15));
      be = 4'($urandom_range(15));
      d  = $urandom;
      drive_step(1'b0, v, we, a, be, d, rr, e);
      checks += 4;
      if (req_ready !== e.ready) begin failures++; $display("FAIL rand_ready got=%b exp=%b cyc=%0d", req_ready, e.ready, cyc); end
      if (resp_valid !== e.rv) begin failures++; $display("FAIL rand_rv got=%b exp=%b cyc=%0d", resp_valid, e.rv, cyc); end
      if ({ram_re, ram_we} !== {e.re, e.we}) begin failures++; $display("FAIL rand_strobes got=%b exp=%b cyc=%0d", {ram_re, ram_we}, {e.re, e.we}, cyc); end
      if ({ram_addr, ram_be, ram_di} !== {a, be, d}) begin failures++; $display("FAIL rand_passthru got=%h/%h/%h exp=%h/%h/%h", ram_addr, ram_be, ram_di, a, be, d); end
      if (e.rv) begin
        checks++;
        if (resp_data !== e.data) begin failures++; $display("FAIL rand_data got=%h exp=%h cyc=%0d", resp_data, e.data, cyc); end
      end
    end
  endtask

`ifdef BRAM_PORT_ADAPTER_WRITE_ACK_EN
  task automatic test_write_ack();
    exp_t e;
    logic [DW-1:0] got [$];
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      drive_step(1'b0, 1'b1, 1'b1, 10'd9, 4'hF, 32'h12345678, 1'b1, e);
      else if (k == 1) drive_step(1'b0, 1'b1, 1'b0, 10'd9, 4'h0, 32'h0, 1'b1, e);
      else             drive_step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, e);
      checks += 2;
      if (resp_valid !== e.rv) begin failures++; $display("FAIL wack_rv got=%b exp=%b cyc=%0d", resp_valid, e.rv, cyc); end
      if ({ram_re, ram_we} !== {e.re, e.we}) begin failures++; $display("FAIL wack_strobes got=%b exp=%b cyc=%0d", {ram_re, ram_we}, {e.re, e.we}, cyc); end
      if (resp_valid && resp_ready) got.push_back(resp_data);
    end
    checks++;
    if (got.size() != 2) begin
      failures++; $display("FAIL wack_count got=%0d exp=2", got.size());
    end else begin
      checks += 2;
      if (got[0] !== 32'h0) begin failures++; $display("FAIL wack_zero got=%h exp=00000000", got[0]); end
      if (got[1] !== 32'h12345678) begin failures++; $display("FAIL wack_read got=%h exp=12345678", got[1]); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    RST = 1'b1; ram_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_data = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_full_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
`ifdef BRAM_PORT_ADAPTER_WRITE_ACK_EN
    test_write_ack();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
